// File: rtl/frame_scheduler_pkg.sv
// Shared types and default constants for the frame scheduler.
package frame_scheduler_pkg;

    localparam int unsigned N_DEFAULT     = 256;
    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ      = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/frame_scheduler_if.sv
// Handshake bundle between the scheduler, the ping-pong buffer and the FFT.
interface frame_scheduler_if
    import frame_scheduler_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) ();

    logic             enable;
    logic             paquet_ready;
    logic             fft_ready;
    logic             fft_done;
    logic             valid_window;
    logic             frame_start;
    logic             frame_last;
    logic             busy;
    logic             pending;
    logic             overflow;
    logic [CNT_W-1:0] frame_count;
    logic [CNT_W-1:0] drop_count;

    // Scheduler side
    modport master (
        input  enable, paquet_ready, fft_ready, fft_done,
        output valid_window, frame_start, frame_last, busy, pending, overflow,
        output frame_count, drop_count
    );

    // Buffer / FFT / control side
    modport slave (
        output enable, paquet_ready, fft_ready, fft_done,
        input  valid_window, frame_start, frame_last, busy, pending, overflow,
        input  frame_count, drop_count
    );

endinterface

// File: rtl/frame_scheduler.sv
// Schedules N-sample frame reads from a ping-pong buffer into an FFT,
// tracking one pending bank and counting completed and dropped frames.
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    frame_scheduler_if.master   sched_io
);

    localparam int unsigned      RD_W    = $clog2(N);
    localparam logic [RD_W-1:0]  RD_LAST = RD_W'(N - 1);

    state_e           state_q, state_d;
    logic [RD_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic             pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             valid_q, start_q, last_q, busy_q;
    logic             launch;

    // Next-state, bank bookkeeping and counters
    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        pending_d   = pending_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        launch      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending_q && sched_io.fft_ready && sched_io.enable) begin
                    launch   = 1'b1;
                    state_d  = READ;
                    rd_cnt_d = '0;
                end
            end
            READ: begin
                if (rd_cnt_q == RD_LAST) begin
                    state_d     = WAIT_DONE;
                    rd_cnt_d    = '0;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end else begin
                    rd_cnt_d = rd_cnt_q + RD_W'(1);
                end
            end
            WAIT_DONE: begin
                if (sched_io.fft_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new bank while one is still unclaimed is a drop; the bank stays pending
        if (sched_io.paquet_ready) begin
            pending_d = 1'b1;
            if (pending_q && !launch) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + CNT_W'(1);
                end
            end
        end else if (launch) begin
            pending_d = 1'b0;
        end
    end

    // State and registered outputs, derived from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_cnt_q    <= '0;
            pending_q   <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            valid_q     <= 1'b0;
            start_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            valid_q     <= (state_d == READ);
            start_q     <= (state_d == READ) && (rd_cnt_d == '0);
            last_q      <= (state_d == READ) && (rd_cnt_d == RD_LAST);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign sched_io.valid_window = valid_q;
    assign sched_io.frame_start  = start_q;
    assign sched_io.frame_last   = last_q;
    assign sched_io.busy         = busy_q;
    assign sched_io.pending      = pending_q;
    assign sched_io.overflow     = overflow_q;
    assign sched_io.frame_count  = frame_cnt_q;
    assign sched_io.drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed and randomized checks of frame_scheduler against a frame-level model.
module tb_frame_scheduler;
    import frame_scheduler_pkg::*;

    localparam int unsigned N     = 8;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned VW    = 6 + 2 * CNT_W;
    localparam int          MAXC  = (1 << CNT_W) - 1;

    typedef logic [VW-1:0] vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // Model: remaining read cycles of the current frame, waiting-for-FFT flag, bank and counters
    int m_left;
    bit m_wait, m_pend, m_ovf;
    int m_frames, m_drops;

    always #5 clk = ~clk;

    frame_scheduler_if #(.CNT_W(CNT_W)) bus ();

    frame_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .sched_io (bus)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
        $fatal(1);
    end

    function automatic vec_t obs();
        return {bus.valid_window, bus.frame_start, bus.frame_last, bus.busy,
                bus.pending, bus.overflow, bus.frame_count, bus.drop_count};
    endfunction

    function automatic vec_t mk(bit v, bit s, bit l, bit b, bit p, bit o, int fc, int dc);
        return {v, s, l, b, p, o, CNT_W'(fc), CNT_W'(dc)};
    endfunction

    function automatic vec_t model_vec();
        return mk(m_left > 0, m_left == int'(N), m_left == 1, (m_left > 0) || m_wait,
                  m_pend, m_ovf, m_frames, m_drops);
    endfunction

    function automatic void model_clear();
        m_left = 0; m_wait = 0; m_pend = 0; m_ovf = 0; m_frames = 0; m_drops = 0;
    endfunction

    function automatic void model_step();
        bit idle;
        bit start;
        idle  = (m_left == 0) && !m_wait;
        start = idle && m_pend && bus.fft_ready && bus.enable;
        if (bus.paquet_ready) begin
            if (m_pend && !start) begin
                m_ovf = 1;
                if (m_drops < MAXC) m_drops++;
            end
            m_pend = 1;
        end else if (start) begin
            m_pend = 0;
        end
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_wait   = 1;
                m_frames = (m_frames + 1) % (MAXC + 1);
            end
        end else if (m_wait) begin
            if (bus.fft_done) m_wait = 0;
        end else if (start) begin
            m_left = N;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) model_clear();
        else       model_step();
        #1;
    endtask

    task automatic drive(bit pr, bit rdy, bit en, bit done);
        bus.paquet_ready = pr;
        bus.fft_ready    = rdy;
        bus.enable       = en;
        bus.fft_done     = done;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_clear();
        drive(0, 0, 0, 0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0);
        #2;
        checks++;
        if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_async got %h exp %h", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0));
        end
        tick();
        checks++;
        if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_held got %h exp %h", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0));
        end
        apply_reset();
    endtask

    task automatic test_single_frame();
        vec_t e;
        apply_reset();
        for (int c = 0; c <= 35; c++) begin
            e = mk(c >= 12 && c <= 19, c == 12, c == 19, c >= 12 && c <= 30,
                   c == 11, 0, (c >= 20) ? 1 : 0, 0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL single_frame c=%0d got %h exp %h", c, obs(), e);
            end
            drive(c == 10, 1, 1, c == 30);
            tick();
        end
    endtask

    task automatic test_backpressure();
        vec_t e;
        apply_reset();
        for (int c = 0; c <= 38; c++) begin
            e = mk(c >= 21 && c <= 28, c == 21, c == 28, c >= 21 && c <= 35,
                   c >= 1 && c <= 20, 0, (c >= 29) ? 1 : 0, 0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL backpressure c=%0d got %h exp %h", c, obs(), e);
            end
            drive(c == 0, c >= 20, 1, c == 35);
            tick();
        end
    endtask

    task automatic test_overflow();
        vec_t e;
        int   npulse;
        int   exp_drop;
        apply_reset();
        npulse = 0;
        for (int c = 0; c <= 12; c++) begin
            exp_drop = (npulse > 1) ? ((npulse - 1 > MAXC) ? MAXC : npulse - 1) : 0;
            e = mk(0, 0, 0, 0, c >= 2, exp_drop > 0, 0, exp_drop);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL overflow c=%0d got %h exp %h", c, obs(), e);
            end
            drive((c % 2 == 1) && (c < 10), 0, 1, 0);
            if ((c % 2 == 1) && (c < 10)) npulse++;
            tick();
        end
    endtask

    task automatic test_coincident();
        vec_t e;
        int   fc;
        apply_reset();
        for (int c = 0; c <= 27; c++) begin
            fc = (c >= 22) ? 2 : ((c >= 10) ? 1 : 0);
            e = mk((c >= 2 && c <= 9) || (c >= 14 && c <= 21), c == 2 || c == 14,
                   c == 9 || c == 21, (c >= 2 && c <= 12) || (c >= 14 && c <= 24),
                   c >= 1 && c <= 13, 0, fc, 0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL coincident c=%0d got %h exp %h", c, obs(), e);
            end
            drive(c <= 1, 1, 1, c == 12 || c == 24);
            tick();
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            drive(c == 0, 1, 1, 0);
            tick();
        end
        checks++;
        if (bus.valid_window !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre got %b exp 1", bus.valid_window);
        end
        reset = 1'b1;
        model_clear();
        #1;
        checks++;
        if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL midreset_async got %h exp %h", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0));
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0)) begin
                errors++;
                $display("FAIL midreset_idle c=%0d got %h exp %h", c, obs(), mk(0, 0, 0, 0, 0, 0, 0, 0));
            end
            drive(0, 1, 1, 0);
            tick();
        end
        drive(1, 1, 1, 0);
        tick();
        drive(0, 1, 1, 0);
        tick();
        checks++;
        if (obs() !== mk(1, 1, 0, 1, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL midreset_fresh got %h exp %h", obs(), mk(1, 1, 0, 1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        for (int f = 0; f < 5; f++) begin
            drive(1, 1, 1, 0);
            tick();
            drive(0, 1, 1, 0);
            tick();
            repeat (N) tick();
            checks++;
            if (obs() !== mk(0, 0, 0, 1, 0, 0, (f + 1) % (MAXC + 1), 0)) begin
                errors++;
                $display("FAIL wrap_wait f=%0d got %h exp %h", f, obs(),
                         mk(0, 0, 0, 1, 0, 0, (f + 1) % (MAXC + 1), 0));
            end
            drive(0, 1, 1, 1);
            tick();
            drive(0, 1, 1, 0);
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL wrap_idle f=%0d got %b exp 0", f, bus.busy);
            end
        end
        checks++;
        if (bus.frame_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL wrap_final got %0d exp 1", bus.frame_count);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            checks++;
            if (obs() !== model_vec()) begin
                errors++;
                $display("FAIL random c=%0d got %h exp %h", c, obs(), model_vec());
            end
            drive($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 399) == 0);
            if (reset) model_clear();
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        model_clear();
        drive(0, 0, 0, 0);
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_coincident();
        test_reset_mid_frame();
        test_counter_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
